alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
Execute stage between the register file read ports and the register-file write-back input of the 8-bit multi-cycle CPU. It samples both register operands while the controller is in EX and computes the result and flags. It produces the registered write-back data consumed in RWB and the jump decision for JMP/CMPJ. Single-cycle ops finish in one EX cycle; MUL is an iterative shift-add that stalls EX via ex_busy.

Parameters:
WIDTH, 8, datapath width (only 8 is supported).
MUL_CYCLES, 8, iterations of the shift-add multiplier (equals WIDTH).

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
current_state  input  3  controller state; EX=3'b011, RWB=3'b100
OPCODE  input  4  decoded opcode of the current instruction
op_a  input  8  operand A (register file read port 0)
op_b  input  8  operand B (register file read port 1)
RF_data_in  output  8  registered result, written to RF[RD] in RWB
flag_z  output  1  registered zero flag
flag_c  output  1  registered carry/borrow/overflow flag
jump_taken  output  1  registered jump decision, valid while ex_done=1
ex_busy  output  1  MUL in progress; controller must hold EX
ex_done  output  1  result/flags/jump valid; controller may leave EX

Behaviour:
- Opcodes (shared package): NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOT=6, SHL=7, SHR=8, MUL=9, CMPJ=A, JMP=B, HALT=F. Unlisted opcodes behave as NOP.
- Reset (async, any state): RF_data_in=0, flag_z=0, flag_c=0, jump_taken=0, ex_busy=0, ex_done=0, FSM=S_IDLE, multiplier registers cleared. A reset during MUL aborts it with no partial result.
- FSM states: S_IDLE, S_MUL, S_HOLD.
- S_IDLE, current_state!=EX: hold all outputs.
- S_IDLE, current_state==EX, OPCODE!=MUL: at that edge, register the result and flags, set ex_done=1, go to S_HOLD. Latency is 1 edge.
- S_IDLE, current_state==EX, OPCODE==MUL: latch op_a/op_b, clear the accumulator, set ex_busy=1, count=0, go to S_MUL.
- S_MUL: each edge, if multiplier bit[count]=1, add (multiplicand<<count) into a 16-bit accumulator; count++. After MUL_CYCLES iterations, write RF_data_in=acc[7:0], flag_c=|acc[15:8], flag_z=(acc[7:0]==0), ex_busy=0, ex_done=1, go to S_HOLD. Total latency from the EX-sampling edge to ex_done is 9 edges. Operand changes during S_MUL are ignored.
- S_HOLD: ex_done=1 while current_state==EX. On the first edge with current_state!=EX, clear ex_done and jump_taken and go to S_IDLE. RF_data_in and flags are kept for RWB.
- Arithmetic:
  - ADD: 9-bit sum; C=bit8.
  - SUB: A-B; C=borrow (A<B).
  - AND/OR/XOR: C=0.
  - NOT: ~A, C=0.
  - SHL: A<<1, C=A[7].
  - SHR: A>>1 logical, C=A[0].
  - Z=(result==0) for all ops above.
- CMPJ: jump_taken=(A==B); RF_data_in and flags unchanged.
- JMP: jump_taken=1; RF_data_in and flags unchanged.
- NOP/HALT: RF_data_in, flags and jump_taken=0 unchanged; ex_done is still asserted.
- If current_state leaves EX while in S_MUL (controller protocol violation): abort to S_IDLE with ex_busy=0; outputs are not updated.
- ex_busy and ex_done are never both 1.

Decomposition:
- Shared package alu_pkg: opcode localparams (above), controller state encodings (EX, RWB, and others), and the FSM enum typedef for S_IDLE/S_MUL/S_HOLD.
- One natural sub-module, mul_shift_add: start/busy/done handshake, 8x8 -> 16 bit. Instantiated once in alu_exec.

Test Plan:
- ADD A=0xF0, B=0x20 in EX -> after 1 edge: RF_data_in=0x10, flag_c=1, flag_z=0, ex_done=1, ex_busy=0.
- SUB A=0x05, B=0x05 -> RF_data_in=0x00, flag_z=1, flag_c=0. Then SUB A=0x03, B=0x05 -> RF_data_in=0xFE, flag_c=1.
- MUL A=0x0D, B=0x0B -> ex_busy=1 for 8 cycles, ex_done on edge 9: RF_data_in=0x8F, flag_c=0. MUL A=0x20, B=0x10 -> RF_data_in=0x00, flag_c=1, flag_z=1.
- CMPJ A=B=0x42 -> jump_taken=1, RF_data_in unchanged. CMPJ A=0x42, B=0x43 -> jump_taken=0. JMP -> jump_taken=1. After EX exits: jump_taken=0.
- Reset asserted at MUL cycle 4 -> all outputs 0 immediately (async). After release, a following ADD 1+1 gives 0x02 with 1-edge latency.
- SHL A=0x81 -> 0x02, C=1. SHR A=0x01 -> 0x00, C=1, Z=1. NOT A=0xFF -> 0x00, Z=1. HALT -> ex_done=1, outputs unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: opcodes, controller state codes
// and the execute-stage FSM state type.
package alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_CMPJ = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_IF  = 3'b000;
  localparam logic [2:0] ST_ID  = 3'b001;
  localparam logic [2:0] ST_RR  = 3'b010;
  localparam logic [2:0] ST_EX  = 3'b011;
  localparam logic [2:0] ST_RWB = 3'b100;
  localparam logic [2:0] ST_HLT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } ex_state_t;

endpackage

// File: rtl/alu_exec_mul_shift_add.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// Handshake: start is accepted only while busy=0; busy stays high until the
// edge on which last=1, and product is the final result during that cycle.
module mul_shift_add #(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;
  logic [CW-1:0]      count;

  // product is the accumulator after this cycle's iteration
  always_comb begin
    addend  = mplier[count] ? (mcand << count) : '0;
    product = acc + addend;
    last    = busy && (count == CW'(MUL_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (abort) begin
      acc   <= '0;
      count <= '0;
      busy  <= 1'b0;
    end else if (start && !busy) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      count  <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc <= product;
      if (last) begin
        busy <= 1'b0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: samples operands in EX, produces registered write-back data,
// flags and jump decision; MUL stalls EX through ex_busy.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       current_state,
  input  logic [3:0]       OPCODE,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] RF_data_in,
  output logic             flag_z,
  output logic             flag_c,
  output logic             jump_taken,
  output logic             ex_busy,
  output logic             ex_done
);

  ex_state_t          state;
  logic               in_ex;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_wr;
  logic               mul_start;
  logic               mul_abort;
  logic               mul_busy;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_product;

  assign in_ex     = (current_state == ST_EX);
  assign mul_start = (state == S_IDLE) && in_ex && (OPCODE == OP_MUL) && !mul_busy;
  assign mul_abort = (state == S_MUL) && !in_ex;

  mul_shift_add #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .abort   (mul_abort),
    .a       (op_a),
    .b       (op_b),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_product)
  );

  // alu_wr=0 marks opcodes that leave RF_data_in and flags untouched
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_wr  = 1'b1;
    case (OPCODE)
      OP_ADD: {alu_c, alu_res} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB: begin
        alu_res = op_a - op_b;
        alu_c   = (op_a < op_b);
      end
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_NOT: alu_res = ~op_a;
      OP_SHL: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      default: alu_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      RF_data_in <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      jump_taken <= 1'b0;
      ex_busy    <= 1'b0;
      ex_done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_ex) begin
            if (OPCODE == OP_MUL) begin
              ex_busy <= 1'b1;
              state   <= S_MUL;
            end else begin
              ex_done    <= 1'b1;
              jump_taken <= (OPCODE == OP_JMP) || ((OPCODE == OP_CMPJ) && (op_a == op_b));
              state      <= S_HOLD;
              if (alu_wr) begin
                RF_data_in <= alu_res;
                flag_z     <= (alu_res == '0);
                flag_c     <= alu_c;
              end
            end
          end
        end
        S_MUL: begin
          // leaving EX mid-multiply drops the operation without a result
          if (!in_ex) begin
            ex_busy <= 1'b0;
            state   <= S_IDLE;
          end else if (mul_last) begin
            RF_data_in <= mul_product[WIDTH-1:0];
            flag_c     <= |mul_product[2*WIDTH-1:WIDTH];
            flag_z     <= (mul_product[WIDTH-1:0] == '0);
            ex_busy    <= 1'b0;
            ex_done    <= 1'b1;
            state      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!in_ex) begin
            ex_done    <= 1'b0;
            jump_taken <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: vector table plus hand sequences for
// async reset during MUL and a MUL aborted by leaving EX.
module tb_alu_exec;
  import alu_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] current_state;
  logic [3:0] OPCODE;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] RF_data_in;
  logic       flag_z;
  logic       flag_c;
  logic       jump_taken;
  logic       ex_busy;
  logic       ex_done;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] rf;
    logic       z;
    logic       c;
    logic       j;
  } vec_t;

  vec_t vecs[19];

  alu_exec dut (
    .clk           (clk),
    .reset         (reset),
    .current_state (current_state),
    .OPCODE        (OPCODE),
    .op_a          (op_a),
    .op_b          (op_b),
    .RF_data_in    (RF_data_in),
    .flag_z        (flag_z),
    .flag_c        (flag_c),
    .jump_taken    (jump_taken),
    .ex_busy       (ex_busy),
    .ex_done       (ex_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] rf, input logic z,
                               input logic c, input logic j, input logic busy, input logic done);
    check({tag, ".rf"},   16'(RF_data_in), 16'(rf));
    check({tag, ".z"},    16'(flag_z),     16'(z));
    check({tag, ".c"},    16'(flag_c),     16'(c));
    check({tag, ".jump"}, 16'(jump_taken), 16'(j));
    check({tag, ".busy"}, 16'(ex_busy),    16'(busy));
    check({tag, ".done"}, 16'(ex_done),    16'(done));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge after one RWB cycle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] rf, input logic z,
                        input logic c, input logic j);
    int lat;
    int exp_lat;
    exp_lat = (op == OP_MUL) ? 9 : 1;
    current_state = ST_EX;
    OPCODE        = op;
    op_a          = a;
    op_b          = b;
    lat = 0;
    while (!ex_done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (op == OP_MUL && lat == 1) begin
        op_a = 8'($urandom);
        op_b = 8'($urandom);
      end
      check({tag, ".busy_excl"}, 16'(ex_busy), 16'((op == OP_MUL) && !ex_done));
    end
    check({tag, ".latency"}, 16'(lat), 16'(exp_lat));
    check_outputs({tag, ".ex"}, rf, z, c, j, 1'b0, 1'b1);
    current_state = ST_RWB;
    OPCODE        = 4'(op + 4'h3);
    @(negedge clk);
    check_outputs({tag, ".rwb"}, rf, z, c, 1'b0, 1'b0, 1'b0);
    current_state = ST_IF;
    @(negedge clk);
    check_outputs({tag, ".idle"}, rf, z, c, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    current_state = ST_IF;
    OPCODE        = OP_NOP;
    op_a          = 8'h00;
    op_b          = 8'h00;

    //            op       a      b      rf     z     c     j
    vecs[0]  = '{OP_ADD,  8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{OP_MUL,  8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_MUL,  8'h20, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{OP_CMPJ, 8'h42, 8'h42, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{OP_CMPJ, 8'h42, 8'h43, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{OP_JMP,  8'h11, 8'h22, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{OP_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_OR,   8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_XOR,  8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{OP_SHL,  8'h81, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{OP_SHR,  8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{OP_NOT,  8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{OP_HALT, 8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{OP_NOP,  8'h05, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[17] = '{OP_MUL,  8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{4'hC,    8'h33, 8'h44, 8'h01, 1'b0, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].rf, vecs[i].z, vecs[i].c, vecs[i].j);
    end

    // async reset in the middle of a multiply
    current_state = ST_EX;
    OPCODE        = OP_MUL;
    op_a          = 8'h03;
    op_b          = 8'h03;
    repeat (4) @(negedge clk);
    check_outputs("mul_cycle4", 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 check_outputs("async_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    current_state = ST_RWB;
    reset         = 1'b0;
    @(negedge clk);
    check_outputs("after_reset_release", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_after_reset", OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

    // controller leaves EX while the multiplier is running
    current_state = ST_EX;
    OPCODE        = OP_MUL;
    op_a          = 8'h07;
    op_b          = 8'h09;
    repeat (3) @(negedge clk);
    check("abort.busy_before", 16'(ex_busy), 16'(1'b1));
    current_state = ST_RWB;
    @(negedge clk);
    check_outputs("mul_abort", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    check_outputs("mul_abort_quiet", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_after_abort", OP_SUB, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);
    run_op("mul_after_abort", OP_MUL, 8'h07, 8'h09, 8'h3F, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
